// File: rtl/ccw_wd_buf.sv
// Channel word buffer: 4x36 circular FIFO between memory and channel.
// Optional head-word parity storage: define CCW_WD_BUF_PAR_EN.
module ccw_wd_buf (
  input  logic        clk_ccw_h,
  input  logic        ch_mr_reset_l,
  input  logic        ccl_ccw_reg_load_h,
  input  logic [10:0] ccl_wc_in_h,
  input  logic        ccl_zero_fill_h,
  input  logic        ccl_buf_clr_l,
  output logic        ccw_mem_req_h,
  input  logic [35:0] mb_data_h,
  input  logic        mb_valid_h,
  output logic [35:0] ccw_chan_data_h,
  output logic        ccw_wd_ready_l,
  input  logic        ccl_wd_taken_h,
  output logic [2:0]  ccw_buf_cnt_h,
  output logic        ccw_wcEq0_l,
  output logic        ccw_xfer_done_h,
  output logic        ccw_ovf_err_l,
  output logic        ccw_wd_par_h
);

`ifdef CCW_WD_BUF_PAR_EN
  localparam int EW = 37;
`else
  localparam int EW = 36;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  cnt_q;
  logic [10:0] wc_rem_q;
  logic        zf_q;
  logic        done_q, done_d;
  logic        err_q;
  logic [EW-1:0] mem_q [4];

  logic        full, pop, in_fill;
  logic        zf_push, mb_req, push, ovf;
  logic        start_ok;
  logic [35:0] push_word;
  logic [EW-1:0] push_entry;

  // Push/pop qualification for the current cycle
  always_comb begin
    full      = (cnt_q == 3'd4);
    pop       = ccl_wd_taken_h && (cnt_q != 3'd0);
    in_fill   = (state_q == FILL);
    zf_push   = in_fill && zf_q && (wc_rem_q != 11'd0)
                && (!full || pop);
    mb_req    = in_fill && !zf_q && mb_valid_h
                && (wc_rem_q != 11'd0);
    push      = zf_push || (mb_req && (!full || pop));
    ovf       = mb_req && full && !pop;
    start_ok  = (state_q == IDLE) && ccl_ccw_reg_load_h;
    push_word = zf_q ? 36'd0 : mb_data_h;
`ifdef CCW_WD_BUF_PAR_EN
    push_entry = {~^push_word, push_word};
`else
    push_entry = push_word;
`endif
  end

  // Transfer sequencing and done pulse generation
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ccl_ccw_reg_load_h) begin
          if (ccl_wc_in_h != 11'd0) state_d = FILL;
          else                      done_d  = 1'b1;
        end
      end
      FILL: begin
        if (push && (wc_rem_q == 11'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer, pointers, word count and status registers
  always_ff @(posedge clk_ccw_h or negedge ch_mr_reset_l) begin
    if (!ch_mr_reset_l) begin
      state_q  <= IDLE;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      cnt_q    <= 3'd0;
      wc_rem_q <= 11'd0;
      zf_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else if (!ccl_buf_clr_l) begin
      state_q  <= IDLE;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      cnt_q    <= 3'd0;
      wc_rem_q <= 11'd0;
      zf_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (push) begin
        mem_q[wptr_q] <= push_entry;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
      if (start_ok && (ccl_wc_in_h != 11'd0)) begin
        wc_rem_q <= ccl_wc_in_h;
        zf_q     <= ccl_zero_fill_h;
      end else if (push) begin
        wc_rem_q <= wc_rem_q - 11'd1;
      end
      if (ovf) err_q <= 1'b1;
    end
  end

  // Output decode
  always_comb begin
    ccw_mem_req_h   = in_fill && !zf_q && (wc_rem_q != 11'd0) && !full;
    ccw_chan_data_h = mem_q[rptr_q][35:0];
    ccw_wd_ready_l  = (cnt_q == 3'd0);
    ccw_buf_cnt_h   = cnt_q;
    ccw_wcEq0_l     = (wc_rem_q != 11'd0);
    ccw_xfer_done_h = done_q;
    ccw_ovf_err_l   = ~err_q;
`ifdef CCW_WD_BUF_PAR_EN
    ccw_wd_par_h    = mem_q[rptr_q][36];
`else
    ccw_wd_par_h    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ccw_wd_buf.sv
// Scoreboard bench for ccw_wd_buf: random memory responder and
// random channel taker around a queue of expected words.
module tb_ccw_wd_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [10:0] wc;
  logic        zf;
  logic        clr_l;
  logic        mem_req;
  logic [35:0] mb_data;
  logic        mb_valid;
  logic [35:0] chan;
  logic        ready_l;
  logic        taken;
  logic [2:0]  cnt;
  logic        wceq0_l;
  logic        done;
  logic        err_l;
  logic        par;

  always #5 clk = ~clk;

  ccw_wd_buf dut (
    .clk_ccw_h         (clk),
    .ch_mr_reset_l     (rst_n),
    .ccl_ccw_reg_load_h(load),
    .ccl_wc_in_h       (wc),
    .ccl_zero_fill_h   (zf),
    .ccl_buf_clr_l     (clr_l),
    .ccw_mem_req_h     (mem_req),
    .mb_data_h         (mb_data),
    .mb_valid_h        (mb_valid),
    .ccw_chan_data_h   (chan),
    .ccw_wd_ready_l    (ready_l),
    .ccl_wd_taken_h    (taken),
    .ccw_buf_cnt_h     (cnt),
    .ccw_wcEq0_l       (wceq0_l),
    .ccw_xfer_done_h   (done),
    .ccw_ovf_err_l     (err_l),
    .ccw_wd_par_h      (par)
  );

  int checks = 0;
  int passes = 0;

  logic [35:0] expq[$];
  logic [35:0] fixq[$];
  bit resp_en = 0;
  bit take_en = 0;
  int take_pct = 60;
  int done_cnt = 0;
  bit memreq_seen = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic exp_par(logic [35:0] d);
`ifdef CCW_WD_BUF_PAR_EN
    return ~^d;
`else
    return 1'b0;
`endif
  endfunction

  // Memory side: answer requests with random delay and data
  always @(negedge clk) begin
    logic [63:0] r;
    logic [35:0] d;
    if (resp_en) begin
      if (mem_req === 1'b1 && $urandom_range(0, 99) < 70) begin
        r = {$urandom(), $urandom()};
        d = r[35:0];
        if (fixq.size() > 0) d = fixq.pop_front();
        mb_valid = 1'b1;
        mb_data  = d;
        expq.push_back(d);
      end else begin
        mb_valid = 1'b0;
      end
    end
  end

  // Channel side: take words at random and check against the model
  always @(negedge clk) begin
    logic [35:0] e;
    if (take_en && ready_l === 1'b0 && $urandom_range(0, 99) < take_pct) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %0h expected none", chan);
      end else begin
        e = expq.pop_front();
        chk("chan_data", chan, e);
        chk("par", par, exp_par(e));
      end
      taken = 1'b1;
    end else begin
      taken = 1'b0;
    end
  end

  // Done pulse counter and request observer
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_req === 1'b1) memreq_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int w, bit z);
    load = 1'b1;
    wc   = w[10:0];
    zf   = z;
    if (z) repeat (w) expq.push_back(36'd0);
    tick();
    load = 1'b0;
    zf   = 1'b0;
  endtask

  task automatic wait_done(string nm, int d0, int lim);
    int n = 0;
    while (done_cnt == d0 && n < lim) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_drained"}, expq.size(), 0);
    chk({nm, "_wceq0"}, wceq0_l, 1'b0);
  endtask

  task automatic run_xfer(string nm, int w, bit z);
    int d0 = done_cnt;
    memreq_seen = 0;
    resp_en = 1;
    take_en = 1;
    start(w, z);
    wait_done(nm, d0, 1000);
    if (z) chk({nm, "_no_req"}, memreq_seen, 0);
  endtask

  task automatic wait_cnt(string nm, int c);
    int n = 0;
    while (cnt !== c[2:0] && n < 300) begin
      tick();
      n++;
    end
    chk(nm, cnt, c);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_req"}, mem_req, 0);
    chk({nm, "_ready_l"}, ready_l, 1);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err_l"}, err_l, 1);
    chk({nm, "_cnt"}, cnt, 0);
    chk({nm, "_par"}, par, 0);
    chk({nm, "_data"}, chan, 0);
    chk({nm, "_wceq0"}, wceq0_l, 0);
  endtask

  initial begin
    int d0;
    int n;
    rst_n    = 1'b0;
    load     = 1'b0;
    wc       = '0;
    zf       = 1'b0;
    clr_l    = 1'b1;
    mb_data  = '0;
    mb_valid = 1'b0;
    taken    = 1'b0;
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Word count zero: immediate done, nothing moves
    d0 = done_cnt;
    start(0, 0);
    n = 0;
    while (done_cnt == d0 && n < 5) begin
      tick();
      n++;
    end
    chk("wc0_done", done_cnt - d0, 1);

    fixq = '{36'd1, 36'd2, 36'd3};
    run_xfer("seq123", 3, 0);

    run_xfer("zero_fill", 5, 1);

    fixq = '{36'o000000000001, 36'o0};
    run_xfer("parity", 2, 0);

    // Stalled channel fills the buffer, one take reopens requests
    take_en = 0;
    resp_en = 1;
    d0 = done_cnt;
    start(6, 0);
    wait_cnt("stall_cnt", 4);
    chk("stall_req", mem_req, 0);
    take_pct = 100;
    take_en  = 1;
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    chk("stall_rereq", mem_req, 1);
    take_pct = 60;
    wait_done("stall", d0, 1000);

    // Overflow on full buffer, then flush
    take_en = 0;
    resp_en = 1;
    d0 = done_cnt;
    start(6, 0);
    wait_cnt("ovf_fill", 4);
    resp_en  = 0;
    mb_valid = 1'b1;
    mb_data  = 36'habc;
    tick();
    mb_valid = 1'b0;
    chk("ovf_err", err_l, 0);
    chk("ovf_cnt", cnt, 4);
    chk("ovf_wc_kept", wceq0_l, 1);
    tick();
    chk("ovf_sticky", err_l, 0);
    clr_l = 1'b0;
    tick();
    clr_l = 1'b1;
    expq.delete();
    chk("clr_err", err_l, 1);
    chk("clr_cnt", cnt, 0);
    chk("clr_ready", ready_l, 1);
    chk("clr_wceq0", wceq0_l, 0);
    chk("clr_req", mem_req, 0);
    repeat (3) tick();
    chk("clr_no_done", done_cnt - d0, 0);

    run_xfer("after_clr", 4, 0);

    // Reset mid-fill abandons transfer
    take_en = 0;
    resp_en = 1;
    d0 = done_cnt;
    start(6, 0);
    wait_cnt("rst_fill", 2);
    resp_en  = 0;
    mb_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    expq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_no_done", done_cnt - d0, 0);

    for (int i = 0; i < 10; i++) begin
      run_xfer("rand", $urandom_range(1, 12), $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
